// File: rtl/retry_fsm_pkg.sv
// Shared types and elaboration helpers for the retry_fsm job controller.
package retry_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        BACKOFF = 2'd2,
        FAILED  = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/retry_fsm_if.sv
// Job-start handshake, downstream request/ack and status bundle of retry_fsm.
interface retry_fsm_if
    import retry_fsm_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int MAX_RETRIES = 3
);
    localparam int RC_W = clog2_min1(MAX_RETRIES + 1);

    logic                start_valid_i;
    logic                start_ready_o;
    logic [ID_WIDTH-1:0] start_id_i;
    logic                req_o;
    logic [ID_WIDTH-1:0] req_id_o;
    logic                ack_i;
    logic                clear_i;
    logic                done_o;
    logic                fail_o;
    logic [RC_W-1:0]     retry_cnt_o;
    state_t              state_o;

    // The controller itself sits on the slave side.
    modport slave (
        input  start_valid_i, start_id_i, ack_i, clear_i,
        output start_ready_o, req_o, req_id_o, done_o, fail_o, retry_cnt_o, state_o
    );

    modport master (
        output start_valid_i, start_id_i, ack_i, clear_i,
        input  start_ready_o, req_o, req_id_o, done_o, fail_o, retry_cnt_o, state_o
    );

endinterface

// File: rtl/retry_timer.sv
// Loadable down-counter that sticks at zero; terminal flag marks the last cycle of a window.
module retry_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; zero is sticky so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == '0);

endmodule

// File: rtl/retry_fsm.sv
// Issues a tagged downstream request, retrying with a backoff gap on timeout until success or failure.
module retry_fsm
    import retry_fsm_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BACKOFF_CYCLES = 4,
    parameter int MAX_RETRIES    = 3
) (
    input  logic      clk_i,
    input  logic      rst_i,
    retry_fsm_if.slave bus
);

    localparam int RC_W  = clog2_min1(MAX_RETRIES + 1);
    localparam int TMR_W = clog2_min1(max2(TIMEOUT_CYCLES, BACKOFF_CYCLES));

    // The timer is loaded with length-1 so its terminal flag lands on the final cycle.
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] BO_LOAD = TMR_W'(BACKOFF_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRIES);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [RC_W-1:0]     rc_q, rc_d;

    logic                tmr_load;
    logic                tmr_dec;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_term;

    retry_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .term_o     (tmr_term)
    );

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        rc_d     = rc_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = TO_LOAD;

        case (state_q)
            IDLE: begin
                if (bus.start_valid_i) begin
                    state_d  = BUSY;
                    id_d     = bus.start_id_i;
                    rc_d     = '0;
                    tmr_load = 1'b1;
                end
            end
            // Priority: clear, then ack (so a last-cycle ack still succeeds), then timeout.
            BUSY: begin
                if (bus.clear_i) begin
                    state_d = IDLE;
                end else if (bus.ack_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmr_term) begin
                    if (rc_q < RC_MAX) begin
                        state_d  = BACKOFF;
                        rc_d     = rc_q + RC_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = BO_LOAD;
                    end else begin
                        state_d = FAILED;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            BACKOFF: begin
                if (bus.clear_i) begin
                    state_d = IDLE;
                end else if (tmr_term) begin
                    state_d  = BUSY;
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FAILED: begin
                if (bus.clear_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered level outputs follow the state being entered.
        req_d  = (state_d == BUSY);
        fail_d = (state_d == FAILED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            id_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            id_q    <= id_d;
            rc_q    <= rc_d;
        end
    end

    assign bus.start_ready_o = (state_q == IDLE) && !rst_i;
    assign bus.req_o         = req_q;
    assign bus.req_id_o      = id_q;
    assign bus.done_o        = done_q;
    assign bus.fail_o        = fail_q;
    assign bus.retry_cnt_o   = rc_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_retry_fsm.sv
// Bench for retry_fsm: fixed vector table, hand-built corner sequences, then random traffic vs an arithmetic job model.
module tb_retry_fsm;
    import retry_fsm_pkg::*;

    localparam int IDW = 4;
    localparam int TO  = 4;
    localparam int BO  = 2;
    localparam int MR  = 2;
    localparam int P   = TO + BO;
    localparam int F   = (MR + 1) * TO + MR * BO;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    retry_fsm_if #(.ID_WIDTH(IDW), .MAX_RETRIES(MR)) bus ();

    retry_fsm #(
        .ID_WIDTH       (IDW),
        .TIMEOUT_CYCLES (TO),
        .BACKOFF_CYCLES (BO),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Job model: k counts cycles since the first request cycle of the current job.
    int           m_active = 0;
    int           m_k      = 0;
    logic         m_done   = 1'b0;
    logic [3:0]   m_id     = '0;
    int           m_rc     = 0;

    function automatic int rc_of(input int k);
        if (k >= F) return MR;
        return k / P + (((k % P) >= TO) ? 1 : 0);
    endfunction

    function automatic int m_busy();
        return (m_active != 0) && (m_k < F) && ((m_k % P) < TO);
    endfunction

    function automatic int m_state();
        if (m_active == 0) return 0;
        if (m_k >= F) return 3;
        if ((m_k % P) < TO) return 1;
        return 2;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_active = 0; m_k = 0; m_done = 1'b0; m_id = '0; m_rc = 0;
        end else if (m_active == 0) begin
            m_done = 1'b0;
            if (bus.start_valid_i) begin
                m_active = 1; m_k = 0; m_id = bus.start_id_i; m_rc = 0;
            end
        end else begin
            m_done = 1'b0;
            if (bus.clear_i) begin
                m_active = 0;
            end else if (m_busy() != 0 && bus.ack_i) begin
                m_active = 0;
                m_done   = 1'b1;
            end else if (m_k < F) begin
                m_k  = m_k + 1;
                m_rc = rc_of(m_k);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] id,
                         input logic a, input logic c);
        rst               = r;
        bus.start_valid_i = v;
        bus.start_id_i    = id;
        bus.ack_i         = a;
        bus.clear_i       = c;
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("req",   bus.req_o,         m_busy());
        chk("done",  bus.done_o,        m_done);
        chk("fail",  bus.fail_o,        (m_active != 0) && (m_k >= F));
        chk("ready", bus.start_ready_o, (m_active == 0) && !rst);
        chk("state", bus.state_o,       m_state());
        chk("rc",    bus.retry_cnt_o,   m_rc);
        chk("id",    bus.req_id_o,      m_id);
    endtask

    typedef struct {
        logic       rst, valid;
        logic [3:0] id;
        logic       ack, clr;
        logic       e_req, e_done, e_fail, e_rdy;
        logic [1:0] e_st, e_rc;
        logic [3:0] e_id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [3:0] id, input logic a,
                       input logic c, input logic eq, input logic ed, input logic ef,
                       input logic er, input logic [1:0] es, input logic [1:0] ec,
                       input logic [3:0] ei);
        vec_t t;
        t.rst = r; t.valid = v; t.id = id; t.ack = a; t.clr = c;
        t.e_req = eq; t.e_done = ed; t.e_fail = ef; t.e_rdy = er;
        t.e_st = es; t.e_rc = ec; t.e_id = ei;
        tbl.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [16:0] pat;
        logic [16:0] exp_pat;

        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // rst valid id ack clr | req done fail rdy state rc id
        add(1, 0, 4'h0, 0, 0,  0, 0, 0, 0,  2'd0, 2'd0, 4'h0);
        // accept, ack on 2nd request cycle
        add(0, 1, 4'h5, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h5);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h5);
        add(0, 0, 4'h0, 1, 0,  0, 1, 0, 1,  2'd0, 2'd0, 4'h5);
        add(0, 0, 4'h0, 0, 0,  0, 0, 0, 1,  2'd0, 2'd0, 4'h5);
        // ack and clear while idle are ignored
        add(0, 0, 4'h0, 1, 1,  0, 0, 0, 1,  2'd0, 2'd0, 4'h5);
        // ack on the timeout cycle wins
        add(0, 1, 4'hA, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'hA);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'hA);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'hA);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'hA);
        add(0, 0, 4'h0, 1, 0,  0, 1, 0, 1,  2'd0, 2'd0, 4'hA);
        // timeout into backoff, then clear in the first backoff cycle
        add(0, 1, 4'h3, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h3);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h3);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h3);
        add(0, 0, 4'h0, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h3);
        add(0, 0, 4'h0, 0, 0,  0, 0, 0, 0,  2'd2, 2'd1, 4'h3);
        add(0, 0, 4'h0, 0, 1,  0, 0, 0, 1,  2'd0, 2'd1, 4'h3);
        // start ignored while busy, reset mid-attempt, stale ack afterwards
        add(0, 1, 4'h9, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h9);
        add(0, 1, 4'h7, 0, 0,  1, 0, 0, 0,  2'd1, 2'd0, 4'h9);
        add(1, 0, 4'h0, 0, 0,  0, 0, 0, 0,  2'd0, 2'd0, 4'h0);
        add(0, 0, 4'h0, 1, 0,  0, 0, 0, 1,  2'd0, 2'd0, 4'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].id, tbl[i].ack, tbl[i].clr);
            cycle();
            chk("tbl_req",   bus.req_o,         tbl[i].e_req);
            chk("tbl_done",  bus.done_o,        tbl[i].e_done);
            chk("tbl_fail",  bus.fail_o,        tbl[i].e_fail);
            chk("tbl_ready", bus.start_ready_o, tbl[i].e_rdy);
            chk("tbl_state", bus.state_o,       tbl[i].e_st);
            chk("tbl_rc",    bus.retry_cnt_o,   tbl[i].e_rc);
            chk("tbl_id",    bus.req_id_o,      tbl[i].e_id);
        end

        // Never acked: 4 on, 2 off, 4 on, 2 off, 4 on, then FAILED.
        drive(1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
        cycle();
        pat[0] = bus.req_o;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 1; i < 17; i++) begin
            cycle();
            pat[i] = bus.req_o;
        end
        exp_pat = 17'b0_1111_00_1111_00_1111;
        chk("exhaust_req_pattern", pat, exp_pat);
        chk("exhaust_fail",  bus.fail_o,      1);
        chk("exhaust_state", bus.state_o,     3);
        chk("exhaust_rc",    bus.retry_cnt_o, 2);

        // FAILED refuses new jobs until cleared.
        drive(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("failed_ready", bus.start_ready_o, 0);
            chk("failed_hold",  bus.state_o,       3);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        cycle();
        chk("clear_fail",  bus.fail_o,  0);
        chk("clear_state", bus.state_o, 0);
        chk("clear_done",  bus.done_o,  0);
        drive(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        cycle();
        chk("restart_state", bus.state_o,     1);
        chk("restart_id",    bus.req_id_o,    4'hC);
        chk("restart_rc",    bus.retry_cnt_o, 0);

        // Clear and ack together: clear wins, no done pulse.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        cycle();
        chk("clr_ack_state", bus.state_o, 0);
        chk("clr_ack_done",  bus.done_o,  0);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        chk("clr_ack_done_next", bus.done_o, 0);

        // Random traffic against the job model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0),
                  4'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 24) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
